// File: rtl/gauss_pkg.sv
// Shared types and constants for the Gaussian smoothing stages.
// Kernel is separable: [1 2 1] applied vertically, then horizontally.
package gauss_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    FLUSH,
    ACK,
    FRAME_DONE
  } state_t;

  localparam int KW_OUTER = 1;
  localparam int KW_INNER = 2;
  localparam int ROUND    = 8;
  localparam int SHIFT    = 4;
  localparam int CS_W     = 10;
  localparam int SUM_W    = 12;

endpackage

// File: rtl/gauss_col_sum.sv
// Vertical [1 2 1] pass over one 3-pixel column; shared by the larger kernels.
module gauss_col_sum
  import gauss_pkg::*;
(
  input  logic [7:0]      row0,
  input  logic [7:0]      row1,
  input  logic [7:0]      row2,
  output logic [CS_W-1:0] col_sum
);

  always_comb begin
    col_sum = CS_W'(KW_OUTER) * CS_W'(row0)
            + CS_W'(KW_INNER) * CS_W'(row1)
            + CS_W'(KW_OUTER) * CS_W'(row2);
  end

endmodule

// File: rtl/gauss3x3_window.sv
// Sliding 3x3 Gaussian window fed column-by-column from the row buffer,
// with the row-level idle/done handshake back to that buffer.
module gauss3x3_window
  import gauss_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int HEIGHT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready_i,
  input  logic [7:0] row0_i,
  input  logic [7:0] row1_i,
  input  logic [7:0] row2_i,
  output logic       idle_o,
  output logic       row_done_o,
  output logic [7:0] pix_o,
  output logic       pix_valid_o,
  output logic [7:0] pix_col_o,
  output logic [7:0] pix_row_o,
  output logic       frame_done_o
);

  state_t           state;
  logic [7:0]       col_cnt;
  logic [7:0]       row_cnt;
  logic [CS_W-1:0]  c0, c1, c2;
  logic             shifted;
  logic             accept;
  logic [CS_W-1:0]  col_sum;
  logic [SUM_W-1:0] win_sum;

  gauss_col_sum u_col_sum (
    .row0    (row0_i),
    .row1    (row1_i),
    .row2    (row2_i),
    .col_sum (col_sum)
  );

  always_comb begin
    accept  = ready_i && ((state == IDLE) ||
                          ((state == ROW) && (col_cnt < 8'(WIDTH))));
    win_sum = SUM_W'(KW_OUTER) * SUM_W'(c0)
            + SUM_W'(KW_INNER) * SUM_W'(c1)
            + SUM_W'(KW_OUTER) * SUM_W'(c2);
  end

  // The pixel is produced the cycle after its last column shifts in, so
  // col_cnt and the window here already reflect that shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      col_cnt      <= '0;
      row_cnt      <= '0;
      c0           <= '0;
      c1           <= '0;
      c2           <= '0;
      shifted      <= 1'b0;
      idle_o       <= 1'b1;
      row_done_o   <= 1'b0;
      pix_o        <= '0;
      pix_valid_o  <= 1'b0;
      pix_col_o    <= '0;
      pix_row_o    <= '0;
      frame_done_o <= 1'b0;
    end else begin
      pix_valid_o <= 1'b0;
      shifted     <= accept;

      if (accept) begin
        c2      <= col_sum;
        c1      <= c2;
        c0      <= c1;
        col_cnt <= col_cnt + 8'd1;
      end

      if (shifted && (col_cnt >= 8'd3)) begin
        pix_o       <= 8'((win_sum + SUM_W'(ROUND)) >> SHIFT);
        pix_valid_o <= 1'b1;
        pix_col_o   <= col_cnt - 8'd2;
        pix_row_o   <= row_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (ready_i) state <= ROW;
        end
        ROW: begin
          if (accept && (col_cnt == 8'(WIDTH - 1))) state <= FLUSH;
        end
        FLUSH: begin
          if (shifted) begin
            state      <= ACK;
            row_done_o <= 1'b1;
          end
        end
        ACK: begin
          if (!ready_i) begin
            row_done_o <= 1'b0;
            row_cnt    <= row_cnt + 8'd1;
            if (row_cnt == 8'(HEIGHT - 3)) begin
              state        <= FRAME_DONE;
              idle_o       <= 1'b0;
              frame_done_o <= 1'b1;
            end else begin
              // Each row starts from an empty window.
              state   <= IDLE;
              col_cnt <= '0;
              c0      <= '0;
              c1      <= '0;
              c2      <= '0;
            end
          end
        end
        FRAME_DONE: begin
          state <= FRAME_DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gauss3x3_window.sv
// Randomised bench for gauss3x3_window: a 2D convolution model of the frame
// predicts every pixel and the cycle it must appear on.
module tb_gauss3x3_window;

  localparam int W = 5;
  localparam int H = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] row0_i = '0;
  logic [7:0] row1_i = '0;
  logic [7:0] row2_i = '0;
  logic       idle_o, row_done_o, pix_valid_o, frame_done_o;
  logic [7:0] pix_o, pix_col_o, pix_row_o;

  typedef struct {
    int due;
    int pix;
    int col;
    int row;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_pix = 0;
  logic [7:0] img [H][W];
  exp_t       q[$];
  int         seen[$];
  int         seen_pos[$];

  gauss3x3_window #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .ready_i      (ready_i),
    .row0_i       (row0_i),
    .row1_i       (row1_i),
    .row2_i       (row2_i),
    .idle_o       (idle_o),
    .row_done_o   (row_done_o),
    .pix_o        (pix_o),
    .pix_valid_o  (pix_valid_o),
    .pix_col_o    (pix_col_o),
    .pix_row_o    (pix_row_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Full 3x3 convolution around (rc, cc) with the [1 2 1]x[1 2 1]/16 kernel.
  function automatic int gauss_ref(input int rc, input int cc);
    int s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * int'(img[rc+dr][cc+dc]);
    return (s + 8) / 16;
  endfunction

  task automatic fill_const(input int v);
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) img[i][j] = 8'(v);
  endtask

  task automatic fill_random();
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) img[i][j] = 8'($urandom);
  endtask

  // Drive one cycle of input; an accepted column k>=2 completes a pixel
  // that must show up two edges later.
  task automatic apply_stimulus(input bit rdy, input int r, input int k, input bit acc);
    @(negedge clk);
    ready_i = rdy;
    if (acc) begin
      row0_i = img[r][k];
      row1_i = img[r+1][k];
      row2_i = img[r+2][k];
      if (k >= 2)
        q.push_back('{due: cyc + 2, pix: gauss_ref(r + 1, k - 1), col: k - 1, row: r + 1});
    end else begin
      row0_i = 8'($urandom);
      row1_i = 8'($urandom);
      row2_i = 8'($urandom);
    end
  endtask

  task automatic send_row(input int r, input int stall_after, input int stall_len,
                          input int extra, input bit rnd);
    for (int k = 0; k < W; k++) begin
      apply_stimulus(1'b1, r, k, 1'b1);
      if (k == stall_after) repeat (stall_len) apply_stimulus(1'b0, r, k, 1'b0);
      if (rnd && k < W - 1) repeat ($urandom_range(0, 2)) apply_stimulus(1'b0, r, k, 1'b0);
    end
    repeat (extra) apply_stimulus(1'b1, r, 0, 1'b0);
  endtask

  // Line-buffer side: keep ready high until done is seen, then drop it.
  task automatic finish_row(input bit last);
    int n = 0;
    while (!row_done_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("row_done_rise", int'(row_done_o), 1);
    @(negedge clk);
    check_output("row_done_hold", int'(row_done_o), 1);
    ready_i = 1'b0;
    @(negedge clk);
    check_output("row_done_fall", int'(row_done_o), 0);
    check_output("idle_after_row", int'(idle_o), last ? 0 : 1);
    check_output("frame_done_after_row", int'(frame_done_o), last ? 1 : 0);
  endtask

  task automatic run_frame(input int stall_row, input int stall_after, input int stall_len,
                           input bit rnd);
    for (int r = 0; r <= H - 3; r++) begin
      send_row(r, (r == stall_row) ? stall_after : -1, stall_len, 0, rnd);
      finish_row(r == H - 3);
    end
  endtask

  task automatic assert_reset();
    rst     = 1'b1;
    ready_i = 1'b0;
    #1;
    check_output("rst_idle", int'(idle_o), 1);
    check_output("rst_row_done", int'(row_done_o), 0);
    check_output("rst_pix", int'(pix_o), 0);
    check_output("rst_pix_valid", int'(pix_valid_o), 0);
    check_output("rst_pix_col", int'(pix_col_o), 0);
    check_output("rst_pix_row", int'(pix_row_o), 0);
    check_output("rst_frame_done", int'(frame_done_o), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    assert_reset();
    seen.delete();
    seen_pos.delete();
  endtask

  // Every cycle out of reset: either the scheduled pixel or a quiet, held output.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      last_pix = 0;
    end else if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      check_output("pix_valid", int'(pix_valid_o), 1);
      check_output("pix_value", int'(pix_o), e.pix);
      check_output("pix_col", int'(pix_col_o), e.col);
      check_output("pix_row", int'(pix_row_o), e.row);
      last_pix = e.pix;
      seen.push_back(int'(pix_o));
      seen_pos.push_back(int'(pix_col_o) * 256 + int'(pix_row_o));
    end else begin
      check_output("pix_valid_quiet", int'(pix_valid_o), 0);
      check_output("pix_hold", int'(pix_o), last_pix);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    $display("[TB] gauss3x3_window bench start");
    do_reset();

    // Uniform frame: every pixel keeps its value.
    fill_const(100);
    run_frame(-1, 0, 0, 1'b0);
    check_output("uniform_count", seen.size(), 9);
    check_output("uniform_first", seen[0], 100);
    check_output("uniform_last", seen[8], 100);
    check_output("uniform_first_pos", seen_pos[0], 1 * 256 + 1);
    check_output("uniform_last_pos", seen_pos[8], 3 * 256 + 3);
    repeat (4) apply_stimulus(1'b1, 0, 0, 1'b0);
    @(negedge clk);
    check_output("frame_done_sticky", int'(frame_done_o), 1);
    check_output("frame_done_idle", int'(idle_o), 0);

    // Impulse at the centre row, column 2.
    do_reset();
    fill_const(0);
    img[1][2] = 8'd160;
    run_frame(-1, 0, 0, 1'b0);
    check_output("impulse_c1", seen[0], 20);
    check_output("impulse_c2", seen[1], 40);
    check_output("impulse_c3", seen[2], 20);
    check_output("impulse_r2_c2", seen[4], 20);

    // Rounding corners.
    do_reset();
    fill_const(0);
    for (int j = 0; j < W; j++) img[0][j] = 8'd1;
    run_frame(-1, 0, 0, 1'b0);
    check_output("round_row0_only", seen[0] + seen[1] + seen[2], 0);
    do_reset();
    fill_const(1);
    run_frame(-1, 0, 0, 1'b0);
    check_output("round_all_one", seen[1], 1);
    do_reset();
    fill_const(255);
    run_frame(-1, 0, 0, 1'b0);
    check_output("round_all_255", seen[2], 255);

    // Handshake: ready held past the row, then a normal row follows.
    do_reset();
    fill_random();
    send_row(0, -1, 0, 3, 1'b0);
    finish_row(1'b0);
    check_output("handshake_pixels", seen.size(), 3);
    send_row(1, -1, 0, 0, 1'b0);
    finish_row(1'b0);
    check_output("handshake_next_row", seen_pos[3], 1 * 256 + 2);

    // Stall after column 2.
    do_reset();
    fill_random();
    run_frame(0, 2, 2, 1'b0);
    check_output("stall_count", seen.size(), 9);

    // Reset after three columns, once the first pixel is out.
    do_reset();
    fill_const(77);
    for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 0, k, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_output("midrow_pix_before_reset", int'(pix_o), 77);
    #1;
    assert_reset();
    seen.delete();
    seen_pos.delete();
    fill_random();
    run_frame(-1, 0, 0, 1'b0);
    check_output("midrow_restart_pos", seen_pos[0], 1 * 256 + 1);

    // Random frames with random stalls.
    repeat (3) begin
      do_reset();
      fill_random();
      run_frame(-1, 0, 0, 1'b1);
      check_output("random_count", seen.size(), 9);
    end

    repeat (3) @(negedge clk);
    check_output("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
